// File: rtl/prs_pkg.sv
// Shared types and LFSR helpers for the PRS generator/checker.
// All helpers work on 32-bit containers; callers pass the real length.
package prs_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } chk_state_t;

  typedef struct packed {
    logic [31:0] next_state;
    logic [31:0] bits;
  } beat_t;

  function automatic logic [31:0] len_mask(int len);
    return 32'hFFFF_FFFF >> (32 - len);
  endfunction

  // w Fibonacci steps; bit k of the result is the k-th feedback bit
  function automatic beat_t lfsr_beat(
    logic [31:0] state,
    int          len,
    int          tap,
    int          w
  );
    beat_t r;
    logic  fb;
    r.next_state = state;
    r.bits       = '0;
    for (int k = 0; k < 32; k++) begin
      if (k < w) begin
        fb = r.next_state[5'(len - 1)] ^ r.next_state[5'(tap - 1)];
        r.next_state = {r.next_state[30:0], fb};
        r.bits[k] = fb;
      end
    end
    r.next_state = r.next_state & len_mask(len);
    return r;
  endfunction

  function automatic logic [31:0] lfsr_load(
    logic [31:0] state,
    logic [31:0] data,
    int          len,
    int          w
  );
    logic [31:0] s;
    s = state;
    for (int k = 0; k < 32; k++) begin
      if (k < w) begin
        s = {s[30:0], data[k]};
      end
    end
    return s & len_mask(len);
  endfunction

  function automatic logic [5:0] popcount(logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int k = 0; k < 32; k++) begin
      c = c + {5'd0, v[k]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prs_chk.sv
// Self-synchronising PRS checker: SEARCH/VERIFY/LOCKED FSM and
// saturating bit-error / bit-total counters.
module prs_chk
  import prs_pkg::*;
#(
  parameter int LEN        = 15,
  parameter int TAP        = 14,
  parameter int W          = 8,
  parameter int SYNC_BEATS = 4,
  parameter int LOSS_BEATS = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_vld,
  input  logic [W-1:0]     i_data,
  input  logic             i_clr,
  output logic             o_lock,
  output logic             o_bit_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam int FILL = (LEN + W - 1) / W;
  localparam int BCW  = $clog2(FILL + SYNC_BEATS) + 1;
  localparam int LCW  = $clog2(LOSS_BEATS) + 1;
  localparam int SW   = CNT_W + 7;
  localparam logic [SW-1:0] MAXV =
    {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  chk_state_t       r_st;
  logic [LEN-1:0]   r_s;
  logic [BCW-1:0]   r_beat;
  logic [LCW-1:0]   r_loss;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_bits;
  logic             r_bit_err;

  beat_t            w_pred;
  logic [31:0]      w_load;
  logic [5:0]       w_pop;
  logic             w_mis;
  logic [SW-1:0]    w_err_sum;
  logic [SW-1:0]    w_bit_sum;
  logic [CNT_W-1:0] w_err_nxt;
  logic [CNT_W-1:0] w_bit_nxt;
  logic             w_unused;

  assign w_pred = lfsr_beat(32'(r_s), LEN, TAP, W);
  assign w_load = lfsr_load(32'(r_s), 32'(i_data), LEN, W);
  assign w_pop  = popcount(32'(w_pred.bits[W-1:0] ^ i_data));
  assign w_mis  = |(w_pred.bits[W-1:0] ^ i_data);

  assign w_err_sum = SW'(r_err) + SW'(w_pop);
  assign w_bit_sum = SW'(r_bits) + SW'(W);
  assign w_err_nxt = (w_err_sum > MAXV) ? MAXV[CNT_W-1:0]
                                        : w_err_sum[CNT_W-1:0];
  assign w_bit_nxt = (w_bit_sum > MAXV) ? MAXV[CNT_W-1:0]
                                        : w_bit_sum[CNT_W-1:0];
  assign w_unused  = ^{w_pred, w_load};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st      <= SEARCH;
      r_s       <= '0;
      r_beat    <= '0;
      r_loss    <= '0;
      r_err     <= '0;
      r_bits    <= '0;
      r_bit_err <= 1'b0;
    end else begin
      r_bit_err <= 1'b0;
      if (i_clr) begin
        r_st   <= SEARCH;
        r_beat <= '0;
        r_loss <= '0;
        r_err  <= '0;
        r_bits <= '0;
      end else if (i_vld) begin
        unique case (r_st)
          SEARCH: begin
            r_s <= w_load[LEN-1:0];
            if (r_beat == BCW'(FILL - 1)) begin
              r_st   <= VERIFY;
              r_beat <= '0;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
          VERIFY: begin
            r_s <= w_pred.next_state[LEN-1:0];
            // an all-zero register would "verify" a dead input forever
            if (r_s == '0 || w_mis) begin
              r_st   <= SEARCH;
              r_beat <= '0;
            end else if (r_beat == BCW'(SYNC_BEATS - 1)) begin
              r_st   <= LOCKED;
              r_beat <= '0;
              r_loss <= '0;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
          LOCKED: begin
            r_s       <= w_pred.next_state[LEN-1:0];
            r_err     <= w_err_nxt;
            r_bits    <= w_bit_nxt;
            r_bit_err <= w_mis;
            if (w_mis) begin
              if (r_loss == LCW'(LOSS_BEATS - 1)) begin
                r_st   <= SEARCH;
                r_beat <= '0;
              end else begin
                r_loss <= r_loss + 1'b1;
              end
            end else begin
              r_loss <= '0;
            end
          end
          default: r_st <= SEARCH;
        endcase
      end
    end
  end

  assign o_lock    = (r_st == LOCKED);
  assign o_bit_err = r_bit_err;
  assign o_err_cnt = r_err;
  assign o_bit_cnt = r_bits;

endmodule

// File: rtl/prs_gen_chk.sv
// PRS generator (W bits per enabled beat) plus self-synchronising
// checker scoring an incoming PRS stream.
module prs_gen_chk
  import prs_pkg::*;
#(
  parameter int          LEN        = 15,
  parameter int          TAP        = 14,
  parameter logic [31:0] SEED       = 32'd1,
  parameter int          W          = 8,
  parameter int          SYNC_BEATS = 4,
  parameter int          LOSS_BEATS = 8,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_gen_en,
  input  logic             i_inject,
  output logic             o_gen_vld,
  output logic [W-1:0]     o_gen_data,
  input  logic             i_chk_vld,
  input  logic [W-1:0]     i_chk_data,
  input  logic             i_clr,
  output logic             o_lock,
  output logic             o_bit_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_bit_cnt
);

  logic [LEN-1:0] r_gen_s;
  logic           r_gen_vld;
  logic [W-1:0]   r_gen_data;
  beat_t          w_gen;
  logic           w_unused;

  assign w_gen    = lfsr_beat(32'(r_gen_s), LEN, TAP, W);
  assign w_unused = ^w_gen;

  // inject flips the emitted word only; the LFSR keeps running clean
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gen_s    <= SEED[LEN-1:0];
      r_gen_vld  <= 1'b0;
      r_gen_data <= '0;
    end else begin
      r_gen_vld <= i_gen_en;
      if (i_gen_en) begin
        r_gen_s    <= w_gen.next_state[LEN-1:0];
        r_gen_data <= w_gen.bits[W-1:0] ^ W'(i_inject);
      end
    end
  end

  assign o_gen_vld  = r_gen_vld;
  assign o_gen_data = r_gen_data;

  prs_chk #(
    .LEN        (LEN),
    .TAP        (TAP),
    .W          (W),
    .SYNC_BEATS (SYNC_BEATS),
    .LOSS_BEATS (LOSS_BEATS),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .i_vld     (i_chk_vld),
    .i_data    (i_chk_data),
    .i_clr     (i_clr),
    .o_lock    (o_lock),
    .o_bit_err (o_bit_err),
    .o_err_cnt (o_err_cnt),
    .o_bit_cnt (o_bit_cnt)
  );

endmodule
